// File: rtl/ifetch_ctrl_pkg.sv
// rtl/ifetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
package ifetch_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam int PC_INCR = 4;

  localparam int IMM16_MSB = 15;
  localparam int IMM16_LSB = 0;
  localparam int IMM16_W   = IMM16_MSB - IMM16_LSB + 1;

  localparam int TGT26_MSB = 25;
  localparam int TGT26_LSB = 0;
  localparam int TGT26_W   = TGT26_MSB - TGT26_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// rtl/ifetch_ctrl_if.sv - PC, instruction memory and decode-side signals of the fetch controller
interface ifetch_ctrl_if #(
  parameter int ADDR_W = ifetch_ctrl_pkg::ADDR_W_DEF,
  parameter int DATA_W = ifetch_ctrl_pkg::DATA_W_DEF
);

  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branchtarget;
  logic [ADDR_W-1:0] jumptarget;
  logic              misalign;

  modport slave (
    input  pc_in, pc_valid, flush, imem_ack, imem_rdata, instr_ready,
    output pc_ready, imem_req, imem_addr, instr_valid, instr_out, instr_pc,
           pc_plus4, branchtarget, jumptarget, misalign
  );

  modport master (
    output pc_in, pc_valid, flush, imem_ack, imem_rdata, instr_ready,
    input  pc_ready, imem_req, imem_addr, instr_valid, instr_out, instr_pc,
           pc_plus4, branchtarget, jumptarget, misalign
  );

endinterface

// File: rtl/ifetch_ctrl_target.sv
// rtl/ifetch_ctrl_target.sv - sequential, branch and jump targets of the held instruction
module ifetch_target #(
  parameter int ADDR_W = ifetch_ctrl_pkg::ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]                   instr_pc,
  input  logic [ifetch_ctrl_pkg::IMM16_W-1:0] imm16,
  input  logic [ifetch_ctrl_pkg::TGT26_W-1:0] target26,
  output logic [ADDR_W-1:0]                   pc_plus4,
  output logic [ADDR_W-1:0]                   branchtarget,
  output logic [ADDR_W-1:0]                   jumptarget
);
  import ifetch_ctrl_pkg::*;

  localparam int EXT_W = ADDR_W - IMM16_W - 2;

  logic [ADDR_W-1:0] branch_off;

  // Word offset: sign-extend the immediate and scale by the instruction size.
  assign branch_off   = {{EXT_W{imm16[IMM16_W-1]}}, imm16, 2'b00};

  assign pc_plus4     = instr_pc + ADDR_W'(PC_INCR);
  assign branchtarget = pc_plus4 + branch_off;
  assign jumptarget   = {pc_plus4[ADDR_W-1:TGT26_W+2], target26, 2'b00};

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - single-outstanding instruction fetch controller with flush and misalign detection
module ifetch_ctrl #(
  parameter int ADDR_W = ifetch_ctrl_pkg::ADDR_W_DEF,
  parameter int DATA_W = ifetch_ctrl_pkg::DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  ifetch_ctrl_if.slave bus
);
  import ifetch_ctrl_pkg::*;

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              misalign_q;

  logic              pc_ready;
  logic              pc_aligned;
  logic              pc_hs;
  logic              take_addr;
  logic              take_instr;

  always_comb begin
    state_d    = state_q;
    pc_ready   = 1'b0;
    take_instr = 1'b0;
    pc_aligned = (bus.pc_in[1:0] == 2'b00);

    case (state_q)
      IDLE:    pc_ready = 1'b1;
      HOLD:    pc_ready = bus.instr_ready;
      default: pc_ready = 1'b0;
    endcase

    // A flush cycle never accepts a PC, whatever state we are in.
    pc_hs     = bus.pc_valid && pc_ready && !bus.flush;
    take_addr = pc_hs && pc_aligned;

    case (state_q)
      IDLE: begin
        if (take_addr) state_d = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          state_d    = bus.flush ? IDLE : HOLD;
          take_instr = !bus.flush;
        end else if (bus.flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ack) state_d = IDLE;
      end
      HOLD: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.instr_ready) begin
          state_d = take_addr ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= pc_hs && !pc_aligned;
      if (take_addr) begin
        addr_q <= bus.pc_in;
      end
      if (take_instr) begin
        instr_q <= bus.imem_rdata;
        pc_q    <= addr_q;
      end
    end
  end

  // Request stays up through DROP so the memory can retire the abandoned read.
  assign bus.imem_req    = (state_q == REQ) || (state_q == DROP);
  assign bus.imem_addr   = addr_q;
  assign bus.pc_ready    = pc_ready;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = pc_q;
  assign bus.misalign    = misalign_q;

  ifetch_target #(
    .ADDR_W(ADDR_W)
  ) u_target (
    .instr_pc    (pc_q),
    .imm16       (instr_q[IMM16_MSB:IMM16_LSB]),
    .target26    (instr_q[TGT26_MSB:TGT26_LSB]),
    .pc_plus4    (bus.pc_plus4),
    .branchtarget(bus.branchtarget),
    .jumptarget  (bus.jumptarget)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - self-checking bench for ifetch_ctrl
module tb_ifetch_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic        mem_en     = 1'b0;
  logic        rand_lat   = 1'b0;
  int          ack_lat    = 0;
  int          lat_cur    = 0;
  int          wait_cnt   = 0;
  logic        auto_ack   = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        man_ack    = 1'b0;
  logic [31:0] man_rdata  = '0;

  ifetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ifetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_ack   = mem_en ? auto_ack   : man_ack;
  assign bus.imem_rdata = mem_en ? auto_rdata : man_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks lat_cur cycles after the request first appears.
  always begin
    @(posedge clk);
    #2;
    if (mem_en && bus.imem_req) begin
      if (wait_cnt >= lat_cur) begin
        auto_ack   = 1'b1;
        auto_rdata = mem_word(bus.imem_addr);
        wait_cnt   = 0;
      end else begin
        auto_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      auto_ack = 1'b0;
      wait_cnt = 0;
      lat_cur  = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [31:0] a);
    bus.pc_valid = 1'b1;
    bus.pc_in    = a;
    cyc();
    bus.pc_valid = 1'b0;
  endtask

  task automatic manual_ack(input logic [31:0] d);
    man_ack   = 1'b1;
    man_rdata = d;
    cyc();
    man_ack   = 1'b0;
  endtask

  task automatic consume();
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req got=%0h exp=0", bus.imem_req); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid got=%0h exp=0", bus.instr_valid); end
    n_checks++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got=%0h exp=0", bus.misalign); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_imem_addr got=%08h exp=0", bus.imem_addr); end
    n_checks++; if (bus.instr_out !== 32'h0) begin n_fail++; $display("FAIL rst_instr_out got=%08h exp=0", bus.instr_out); end
    n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc got=%08h exp=0", bus.instr_pc); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pc_ready got=%0h exp=1", bus.pc_ready); end
    cyc();
  endtask

  task automatic test_fetch();
    int req_cyc = -1;
    int ack_cyc = -1;
    int vld_cyc = -1;
    mem_en = 1'b1; rand_lat = 1'b0; ack_lat = 2;
    start_fetch(32'h0040_0000);
    for (int c = 0; c < 20 && vld_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.imem_req && req_cyc < 0) req_cyc = c;
      if (bus.imem_req && bus.imem_ack && ack_cyc < 0) ack_cyc = c;
      if (bus.instr_valid) vld_cyc = c;
      cyc();
    end
    n_checks++; if (req_cyc != 0) begin n_fail++; $display("FAIL fetch_req_cycle got=%0d exp=0", req_cyc); end
    n_checks++; if (ack_cyc != 2) begin n_fail++; $display("FAIL fetch_ack_cycle got=%0d exp=2", ack_cyc); end
    n_checks++; if (vld_cyc != 3) begin n_fail++; $display("FAIL fetch_latency got=%0d exp=3", vld_cyc); end
    @(negedge clk);
    n_checks++; if (bus.instr_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL fetch_instr_pc got=%08h exp=00400000", bus.instr_pc); end
    n_checks++; if (bus.pc_plus4 !== 32'h0040_0004) begin n_fail++; $display("FAIL fetch_pc_plus4 got=%08h exp=00400004", bus.pc_plus4); end
    n_checks++; if (bus.instr_out !== mem_word(32'h0040_0000)) begin n_fail++; $display("FAIL fetch_instr_out got=%08h exp=%08h", bus.instr_out, mem_word(32'h0040_0000)); end
    n_checks++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_hold_pc_ready got=%0h exp=0", bus.pc_ready); end
    cyc();
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== mem_word(32'h0040_0000)) begin n_fail++; $display("FAIL fetch_hold_stable got=%0h/%08h exp=1/%08h", bus.instr_valid, bus.instr_out, mem_word(32'h0040_0000)); end
    consume();
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_consumed got=%0h/%0h exp=0/1", bus.instr_valid, bus.pc_ready); end
    cyc();
    mem_en = 1'b0;
  endtask

  task automatic test_targets();
    start_fetch(32'h0040_0010);
    manual_ack(32'h1000_FFFF);
    @(negedge clk);
    n_checks++; if (bus.branchtarget !== 32'h0040_0010) begin n_fail++; $display("FAIL tgt_branch_neg got=%08h exp=00400010", bus.branchtarget); end
    n_checks++; if (bus.pc_plus4 !== 32'h0040_0014) begin n_fail++; $display("FAIL tgt_pc_plus4 got=%08h exp=00400014", bus.pc_plus4); end
    cyc();
    consume();
    start_fetch(32'h0040_0020);
    manual_ack(32'h0810_0000);
    @(negedge clk);
    n_checks++; if (bus.jumptarget !== 32'h0040_0000) begin n_fail++; $display("FAIL tgt_jump got=%08h exp=00400000", bus.jumptarget); end
    n_checks++; if (bus.branchtarget !== 32'h0040_0024) begin n_fail++; $display("FAIL tgt_branch_zero got=%08h exp=00400024", bus.branchtarget); end
    cyc();
    consume();
    start_fetch(32'hFFFF_FFFC);
    manual_ack(32'h0000_8000);
    @(negedge clk);
    n_checks++; if (bus.pc_plus4 !== 32'h0000_0000) begin n_fail++; $display("FAIL tgt_wrap_plus4 got=%08h exp=00000000", bus.pc_plus4); end
    n_checks++; if (bus.branchtarget !== 32'hFFFE_0000) begin n_fail++; $display("FAIL tgt_wrap_branch got=%08h exp=fffe0000", bus.branchtarget); end
    n_checks++; if (bus.jumptarget !== 32'h0002_0000) begin n_fail++; $display("FAIL tgt_wrap_jump got=%08h exp=00020000", bus.jumptarget); end
    cyc();
    consume();
  endtask

  task automatic test_back_to_back();
    start_fetch(32'h0040_0000);
    manual_ack(32'h1234_5678);
    bus.instr_ready = 1'b1;
    bus.pc_valid    = 1'b1;
    bus.pc_in       = 32'h0040_0004;
    @(negedge clk);
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_pc_ready got=%0h exp=1", bus.pc_ready); end
    cyc();
    bus.instr_ready = 1'b0;
    bus.pc_valid    = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_imem_req got=%0h exp=1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 32'h0040_0004) begin n_fail++; $display("FAIL b2b_imem_addr got=%08h exp=00400004", bus.imem_addr); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_instr_valid got=%0h exp=0", bus.instr_valid); end
    cyc();
    manual_ack(32'hCAFE_0001);
    @(negedge clk);
    n_checks++; if (bus.instr_pc !== 32'h0040_0004 || bus.instr_out !== 32'hCAFE_0001) begin n_fail++; $display("FAIL b2b_second got=%08h/%08h exp=00400004/cafe0001", bus.instr_pc, bus.instr_out); end
    cyc();
    consume();
  endtask

  task automatic test_flush_drop();
    start_fetch(32'h0040_0040);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_req_held got=%0h/%0h exp=1/0", bus.imem_req, bus.instr_valid); end
    n_checks++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL drop_pc_ready got=%0h exp=0", bus.pc_ready); end
    cyc();
    manual_ack(32'hDEAD_BEEF);
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_after_ack got=%0h/%0h exp=0/0", bus.imem_req, bus.instr_valid); end
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL drop_idle_ready got=%0h exp=1", bus.pc_ready); end
    n_checks++; if (bus.instr_out === 32'hDEAD_BEEF) begin n_fail++; $display("FAIL drop_data_discarded got=%08h exp=not deadbeef", bus.instr_out); end
    cyc();
  endtask

  task automatic test_flush_ack();
    start_fetch(32'h0040_0050);
    bus.flush = 1'b1;
    manual_ack(32'hBAD0_0001);
    bus.flush = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ack got=%0h/%0h/%0h exp=0/0/1", bus.instr_valid, bus.imem_req, bus.pc_ready); end
    cyc();
  endtask

  task automatic test_flush_hold();
    start_fetch(32'h0040_0060);
    manual_ack(32'h0000_0011);
    bus.flush       = 1'b1;
    bus.instr_ready = 1'b1;
    bus.pc_valid    = 1'b1;
    bus.pc_in       = 32'h0040_0080;
    cyc();
    bus.flush = 1'b0; bus.instr_ready = 1'b0; bus.pc_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_hold got=%0h/%0h exp=0/0", bus.instr_valid, bus.imem_req); end
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_hold_ready got=%0h exp=1", bus.pc_ready); end
    cyc();
  endtask

  task automatic test_flush_idle();
    bus.flush = 1'b1; bus.pc_valid = 1'b1; bus.pc_in = 32'h0040_0100;
    cyc();
    bus.pc_in = 32'h0040_0102;
    cyc();
    bus.flush = 1'b0; bus.pc_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b0 || bus.misalign !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%0h/%0h exp=0/0", bus.imem_req, bus.misalign); end
    cyc();
  endtask

  task automatic test_misalign();
    bus.pc_valid = 1'b1; bus.pc_in = 32'h0040_0002;
    @(negedge clk);
    n_checks++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL mis_early got=%0h exp=0", bus.misalign); end
    cyc();
    bus.pc_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.misalign !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got=%0h exp=1", bus.misalign); end
    n_checks++; if (bus.imem_req !== 1'b0 || bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL mis_no_req got=%0h/%0h exp=0/1", bus.imem_req, bus.pc_ready); end
    cyc();
    @(negedge clk);
    n_checks++; if (bus.misalign !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_once got=%0h/%0h exp=0/0", bus.misalign, bus.imem_req); end
    cyc();
  endtask

  task automatic test_ack_ignored();
    start_fetch(32'h0040_0300);
    manual_ack(32'h7777_0001);
    consume();
    manual_ack(32'h7777_0002);
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'h7777_0001) begin n_fail++; $display("FAIL stray_ack got=%0h/%08h exp=0/77770001", bus.instr_valid, bus.instr_out); end
    cyc();
  endtask

  task automatic test_reset_midfetch();
    start_fetch(32'h0040_0200);
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_before got=%0h exp=1", bus.imem_req); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async got=%0h/%0h exp=0/0", bus.imem_req, bus.instr_valid); end
    cyc();
    rst_n = 1'b1;
    manual_ack(32'h5555_AAAA);
    @(negedge clk);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_late_ack got=%0h/%0h/%0h exp=0/0/1", bus.instr_valid, bus.imem_req, bus.pc_ready); end
    n_checks++; if (bus.instr_out !== 32'h0) begin n_fail++; $display("FAIL rmid_instr_out got=%08h exp=0", bus.instr_out); end
    cyc();
  endtask

  task automatic test_random();
    logic [31:0]        q_pc[$];
    logic               busy;
    logic               mis_pend;
    logic               exp_rdy;
    logic               acc;
    logic [31:0]        epc, ed, e4, ebr, ejt;
    logic signed [15:0] imm;
    busy = 1'b0; mis_pend = 1'b0;
    mem_en = 1'b1; rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.instr_ready = (c >= 2970) || ($urandom_range(0, 3) != 0);
      bus.pc_valid    = (c < 2970) && ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       bus.pc_in = 32'hFFFF_FFFC;
        1:       bus.pc_in = $urandom() | 32'h1;
        2:       bus.pc_in = $urandom() | 32'h2;
        default: bus.pc_in = $urandom() & 32'hFFFF_FFFC;
      endcase
      @(negedge clk);
      n_checks++; if (bus.misalign !== mis_pend) begin n_fail++; $display("FAIL rnd_misalign c=%0d got=%0h exp=%0h", c, bus.misalign, mis_pend); end
      exp_rdy = !busy || (bus.instr_valid && bus.instr_ready);
      n_checks++; if (bus.pc_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_pc_ready c=%0d got=%0h exp=%0h", c, bus.pc_ready, exp_rdy); end
      n_checks++; if (!busy && (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0)) begin n_fail++; $display("FAIL rnd_idle_quiet c=%0d got=%0h/%0h exp=0/0", c, bus.instr_valid, bus.imem_req); end
      if (busy && bus.imem_req) begin
        n_checks++; if (bus.imem_addr !== q_pc[0]) begin n_fail++; $display("FAIL rnd_imem_addr c=%0d got=%08h exp=%08h", c, bus.imem_addr, q_pc[0]); end
      end
      if (busy && bus.instr_valid && bus.instr_ready) begin
        epc = q_pc.pop_front();
        ed  = mem_word(epc);
        e4  = epc + 32'd4;
        imm = ed[15:0];
        ebr = e4 + 32'(int'(imm) * 4);
        ejt = {e4[31:28], ed[25:0], 2'b00};
        n_checks++; if (bus.instr_pc !== epc) begin n_fail++; $display("FAIL rnd_instr_pc c=%0d got=%08h exp=%08h", c, bus.instr_pc, epc); end
        n_checks++; if (bus.instr_out !== ed) begin n_fail++; $display("FAIL rnd_instr_out c=%0d got=%08h exp=%08h", c, bus.instr_out, ed); end
        n_checks++; if (bus.pc_plus4 !== e4) begin n_fail++; $display("FAIL rnd_pc_plus4 c=%0d got=%08h exp=%08h", c, bus.pc_plus4, e4); end
        n_checks++; if (bus.branchtarget !== ebr) begin n_fail++; $display("FAIL rnd_branch c=%0d got=%08h exp=%08h", c, bus.branchtarget, ebr); end
        n_checks++; if (bus.jumptarget !== ejt) begin n_fail++; $display("FAIL rnd_jump c=%0d got=%08h exp=%08h", c, bus.jumptarget, ejt); end
        busy = 1'b0;
      end
      acc      = bus.pc_valid && exp_rdy;
      mis_pend = acc && (bus.pc_in[1:0] != 2'b00);
      if (acc && bus.pc_in[1:0] == 2'b00) begin
        q_pc.push_back(bus.pc_in);
        busy = 1'b1;
      end
      cyc();
    end
    n_checks++; if (busy) begin n_fail++; $display("FAIL rnd_drain got=busy exp=idle pending=%0d", q_pc.size()); end
    bus.instr_ready = 1'b0;
    bus.pc_valid    = 1'b0;
    mem_en = 1'b0; rand_lat = 1'b0;
  endtask

  initial begin
    bus.pc_in       = '0;
    bus.pc_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    test_reset();
    test_fetch();
    test_targets();
    test_back_to_back();
    test_flush_drop();
    test_flush_ack();
    test_flush_hold();
    test_flush_idle();
    test_misalign();
    test_ack_ignored();
    test_reset_midfetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, instruction address width.
REQ-002 Parameter DATA_W, 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_in  input  ADDR_W  fetch address from the PC register.
REQ-006 pc_valid  input  1  pc_in holds a new fetch address.
REQ-007 pc_ready  output  1  block accepts pc_in this cycle.
REQ-008 flush  input  1  redirect; discard any in-flight or held instruction.
REQ-009 imem_req  output  1  instruction memory read request.
REQ-010 imem_addr  output  ADDR_W  read address, word aligned.
REQ-011 imem_ack  input  1  single-cycle pulse; imem_rdata valid that cycle.
REQ-012 imem_rdata  input  DATA_W  fetched instruction word.
REQ-013 instr_valid  output  1  instr_out, instr_pc and targets valid.
REQ-014 instr_ready  input  1  downstream consumes instruction.
REQ-015 instr_out  output  DATA_W  held instruction.
REQ-016 instr_pc  output  ADDR_W  address of instr_out.
REQ-017 pc_plus4  output  ADDR_W  instr_pc + 4, modulo 2^ADDR_W.
REQ-018 branchtarget  output  ADDR_W  pc_plus4 + (sign-extended instr_out[15:0] << 2), modulo 2^ADDR_W.
REQ-019 jumptarget  output  ADDR_W  {pc_plus4[31:28], instr_out[25:0], 2'b00}.
REQ-020 misalign  output  1  one-cycle pulse: accepted pc_in[1:0] != 0.

Function
REQ-021 FSM states IDLE, REQ, DROP, HOLD.
REQ-022 pc_ready = 1 in IDLE, or in HOLD when instr_ready = 1; 0 otherwise.
REQ-023 A PC handshake occurs when pc_valid && pc_ready && !flush.
- Aligned address: latch it into imem_addr; go to REQ.
- Misaligned address: pulse misalign the next cycle; no request; go to IDLE.
REQ-024 REQ: imem_req = 1 and imem_addr stable until imem_ack.
- On ack: capture imem_rdata into instr_out and imem_addr into instr_pc; go to HOLD.
REQ-025 Fetch latency: instr_valid rises on the cycle after the cycle in which imem_ack is sampled.
REQ-026 HOLD: instr_valid = 1; outputs stable until instr_ready.
- instr_ready without a PC handshake: go to IDLE.
- instr_ready with a PC handshake: go directly to REQ (back-to-back fetch).
REQ-027 flush in REQ without imem_ack: go to DROP; keep imem_req = 1 until ack; discard the data on ack; then IDLE.
REQ-028 flush in the same cycle as imem_ack: discard the data; go to IDLE.
REQ-029 flush in HOLD: instr_valid = 0 the next cycle; go to IDLE; any PC handshake that cycle is ignored.
REQ-030 flush in IDLE: no effect; pc_valid that cycle is not accepted.
REQ-031 imem_ack outside REQ/DROP is ignored.
REQ-032 Target outputs are combinational from instr_out and instr_pc; they are meaningful only while instr_valid = 1.

Reset
REQ-033 rst_n low, asynchronous:
- FSM to IDLE.
- imem_req, instr_valid and misalign to 0.
- imem_addr, instr_out and instr_pc to 0.
REQ-034 Reset deasserted mid-fetch: the outstanding memory transaction is abandoned; the block restarts from IDLE.

Structure
REQ-035 A shared package holds:
- the FSM state enum;
- ADDR_W/DATA_W defaults;
- the constant 4 (PC increment);
- field positions for imm16 [15:0] and target26 [25:0].
REQ-036 One sub-module, ifetch_target, computes pc_plus4, branchtarget and jumptarget combinationally.

Verification
REQ-037 pc_in = 0x00400000 with ack 2 cycles after the request -> instr_valid with instr_pc = 0x00400000 and pc_plus4 = 0x00400004.
REQ-038 instr_out = 0x1000FFFF at 0x00400010 -> branchtarget = 0x00400010.
- instr_out = 0x08100000 -> jumptarget = 0x00400000.
REQ-039 HOLD with instr_ready = 1 and pc_valid = 1 (0x00400004) in the same cycle -> imem_req high the next cycle with imem_addr = 0x00400004 and no IDLE cycle.
REQ-040 flush one cycle before imem_ack -> imem_req held until ack; instr_valid stays 0; then pc_ready = 1.
REQ-041 pc_in = 0x00400002 -> misalign pulses once; imem_req stays 0.
REQ-042 rst_n low during REQ -> imem_req and instr_valid = 0 immediately (asynchronous); a later ack is ignored.
